// File: rtl/activ4a_pkg.sv
// Shared constants, state naming and the elaboration-time transition rule for the activ4a sequence detector.
// Pure definitions, no latency; no flow control (no handshake exists in this slice).
package activ4a_pkg;

    localparam int MAX_LEN = 8;
    localparam int STATE_W = $clog2(MAX_LEN + 1);

    localparam int                   DEF_LEN     = 4;
    localparam logic [DEF_LEN-1:0]   DEF_PATTERN = 4'b1011;

    // State value is the matched-prefix count; SDET is whichever Sn equals LEN.
    typedef enum logic [STATE_W-1:0] {
        S0, S1, S2, S3, S4, S5, S6, S7, S8
    } state_t;

    // Longest suffix of (matched prefix, x) that is also a pattern prefix.
    // pattern is right-aligned: pattern[len-1] is the first bit received.
    function automatic int next_match(input logic [MAX_LEN-1:0] pattern,
                                      input int                 len,
                                      input int                 m,
                                      input logic               x,
                                      input logic               overlap);
        logic [MAX_LEN:0] seq;
        int               n;
        int               res;
        logic             ok;
        res = 0;
        seq = '0;
        n   = m + 1;
        if (m > len) begin
            res = 0;
        end else if (m == len && !overlap) begin
            res = (x == pattern[len-1]) ? 1 : 0;
        end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < m) seq[i] = pattern[len-1-i];
            end
            seq[m] = x;
            // Ascending k: the last hit is the longest valid suffix.
            for (int k = 1; k <= MAX_LEN; k++) begin
                if (k <= len && k <= n) begin
                    ok = 1'b1;
                    for (int j = 0; j < MAX_LEN; j++) begin
                        if (j < k && seq[n-k+j] != pattern[len-1-j]) ok = 1'b0;
                    end
                    if (ok) res = k;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/activ4a_fsm.sv
// Moore serial pattern detector: y pulses for one cycle after the last bit of PATTERN is sampled.
// Latency: y rises in the cycle following the edge that sampled the final bit; no backpressure, one bit per clock.
module activ4a_fsm
    import activ4a_pkg::*;
#(
    parameter int             LEN     = DEF_LEN,
    parameter logic [LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    localparam int                 SW      = $clog2(LEN + 1);
    localparam int                 NS      = 1 << SW;
    localparam logic [SW-1:0]      S_IDLE  = SW'(S0);
    localparam logic [SW-1:0]      SDET    = SW'(LEN);
    localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;

    // Constant table indexed by {state, x}; encodings above LEN map to S0.
    logic [SW-1:0] tbl [2*NS];

    for (genvar gi = 0; gi < 2*NS; gi++) begin : g_tbl
        localparam int NM = next_match(PAT_EXT, LEN, gi / 2, (gi % 2) == 1, OVERLAP);
        assign tbl[gi] = SW'(NM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        y       = 1'b0;
        state_d = tbl[{state_q, x}];
        y       = (state_q == SDET);
    end

endmodule

// File: tb/tb_activ4a_fsm.sv
// Scoreboard bench for activ4a_fsm: overlapping and non-overlapping instances share one bit stream.
// Stimulus pushes expected y per sampled bit; a monitor pops and compares one cycle-step later.
module tb_activ4a_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x = 1'b0;
    logic y_a, y_b;

    int checks = 0;
    int passes = 0;

    bit exp_a[$];
    bit exp_b[$];

    activ4a_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_a (
        .clk(clk), .reset(reset), .x(x), .y(y_a)
    );
    activ4a_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_b (
        .clk(clk), .reset(reset), .x(x), .y(y_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitor: y settles just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_a.size() > 0) check("y_overlap", int'(y_a), int'(exp_a.pop_front()));
        if (exp_b.size() > 0) check("y_no_overlap", int'(y_b), int'(exp_b.pop_front()));
    end

    task automatic step(input bit xv, input bit ya, input bit yb);
        @(negedge clk);
        x = xv;
        exp_a.push_back(ya);
        exp_b.push_back(yb);
    endtask

    task automatic start_test();
        @(negedge clk);
        x = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    typedef struct { bit xv; bit ya; bit yb; } vec_t;

    task automatic run_vec(input vec_t v[$]);
        foreach (v[i]) step(v[i].xv, v[i].ya, v[i].yb);
    endtask

    initial begin
        vec_t v[$];

        // Reset held for two edges while x toggles.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("reset_state_a", int'(dut_a.state_q), 0);
        check("reset_state_b", int'(dut_b.state_q), 0);

        // Basic detect, then asynchronous reset while y is high.
        start_test();
        v = '{'{1,0,0}, '{0,0,0}, '{1,0,0}, '{1,1,1}};
        run_vec(v);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_drop_a", int'(y_a), 0);
        check("async_drop_b", int'(y_b), 0);

        // Overlap vs no-overlap on 1011011.
        start_test();
        v = '{'{1,0,0}, '{0,0,0}, '{1,0,0}, '{1,1,1}, '{0,0,0}, '{1,0,0}, '{1,1,0}};
        run_vec(v);

        // Mismatch at bit 4 must fall back to m=2.
        start_test();
        v = '{'{1,0,0}, '{0,0,0}, '{1,0,0}, '{0,0,0}, '{1,0,0}, '{1,1,1}};
        run_vec(v);

        // Reset mid-sequence discards the partial match.
        start_test();
        v = '{'{1,0,0}, '{0,0,0}, '{1,0,0}};
        run_vec(v);
        @(negedge clk);
        x = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("midreset_state_a", int'(dut_a.state_q), 1);
        check("midreset_state_b", int'(dut_b.state_q), 1);

        @(posedge clk); #2;
        check("scoreboard_drained", exp_a.size() + exp_b.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/activ4a_fsm.md
Name: activ4a_fsm

Overview:
- Moore finite-state machine: serial sequence detector on the single-bit input x.
- Output y pulses high for one cycle each time the programmed bit pattern has been received.
- Leaf block on a single clock domain, driven directly by a serial bit source.

Parameters:
- LEN, 4: pattern length in bits; legal range 2..8.
- PATTERN, 4'b1011: pattern to detect, width LEN. Received MSB first: PATTERN[LEN-1] is the first bit.
- OVERLAP, 1: 1 = overlapping detection (the suffix of a match may start the next one); 0 = after a match, matching restarts from scratch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit, sampled on every rising clk edge.
- y  output  1  detect flag; registered Moore output.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, named reset.
- State encoding: state holds the matched prefix count m, 0..LEN. State register width is clog2(LEN+1).
- Named states: S0 is idle (m=0); S1..S(LEN-1) are partial matches; SDET is m=LEN.
- Reset: state forced to S0 immediately, regardless of clk; y=0 while reset is high. First sample after release is taken at the first rising edge with reset low.
- Transitions, one x sample per clock, no enable:
  - From m < LEN: next = length of the longest suffix of (matched prefix followed by x) that is also a prefix of PATTERN. This is the KMP failure rule: x equal to the expected bit gives m+1; otherwise fall back.
  - From SDET with OVERLAP=1: the same rule is applied to the full pattern followed by x.
  - From SDET with OVERLAP=0: next = 1 if x == PATTERN[LEN-1], else 0.
- The next-state table is computed at elaboration time by a constant function. No runtime table storage.
- Output: y = (state == SDET). Purely a function of the state register, no combinational path from x.
- Latency: y is high in the clock cycle immediately after the edge that sampled the last pattern bit. y lasts exactly one cycle unless the next match completes back-to-back (possible only when PATTERN is self-overlapping).
- Reset mid-sequence: any partial match is discarded. y deasserts asynchronously if it was high.
- Unknown or X on x: no special handling required. The bench always drives 0 or 1.
- Illegal state values (m > LEN, from a wide encoding) transition to S0 on the next edge.

Decomposition:
- Package activ4a_pkg contains:
  - the default PATTERN and LEN constants;
  - the constant function next_match(pattern, len, m, x, overlap), returning the next match count;
  - a state typedef sized for the maximum LEN.
- No sub-module: a single always_ff state register plus an always_comb next-state/output block.
- A generate loop builds the transition table from next_match.

Test Plan:
- Reset: hold reset=1 for 2 cycles, toggle x; expect y=0 throughout, state S0. Assert reset between clock edges; expect y to fall without waiting for an edge.
- Basic detect (defaults): after reset, drive x = 1,0,1,1 on consecutive edges; expect y=1 in the cycle after the 4th edge only, and y=0 before.
- Overlap (OVERLAP=1): x = 1,0,1,1,0,1,1; expect y pulses after the 4th and 7th bits (2 pulses).
- No overlap (OVERLAP=0): same stream 1,0,1,1,0,1,1; expect exactly one y pulse, after the 4th bit.
- Fallback: x = 1,0,1,0,1,1; expect a single y pulse after the 6th bit. The mismatch at bit 4 must fall back to m=2, not m=0.
- Reset mid-operation: x = 1,0,1, then reset pulse, then x = 1; expect no y pulse, and state S1 after the final edge.
